// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : cfg_chain_loader
// Purpose  : Host-side master of the serial configuration chain. Converts
//            byte-wide host writes (valid/ready) into an LSB-first bit stream
//            of exactly num_bits bits on prog_out/prog_en, and packs the bits
//            returning on the chain tail (prog_in) into readback bytes.
// Ports    : prog_clk             - configuration clock
//            rst                  - synchronous active-high reset
//            start, num_bits      - load command and total bit count
//            din, din_valid/ready - config byte stream (bit 0 shifted first)
//            prog_out, prog_en    - serial data / shift enable to the fabric
//            prog_in              - chain tail from the fabric
//            rb_data, rb_valid    - readback byte (LSB = earliest bit), strobe
//            busy, done           - load in progress / end-of-load pulse
// Revision : 1.0 - initial release
// ============================================================================
module cfg_chain_loader #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             prog_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_bits,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             prog_out,
  output logic             prog_en,
  input  logic             prog_in,
  output logic [7:0]       rb_data,
  output logic             rb_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] rem_q,       rem_d;       // bits not yet presented
  logic [7:0]       shreg_q,     shreg_d;
  logic [3:0]       nb_q,        nb_d;        // bits used from current byte
  logic [3:0]       idx_q,       idx_d;       // index of bit on prog_out
  logic             prog_out_q,  prog_out_d;
  logic             prog_en_q,   prog_en_d;
  logic             din_ready_q, din_ready_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [7:0]       rb_data_q,   rb_data_d;
  logic             rb_valid_q,  rb_valid_d;
  logic [7:0]       rb_sr_q,     rb_sr_d;
  logic [2:0]       rb_cnt_q,    rb_cnt_d;

  logic             w_accept;
  logic [3:0]       w_nb;
  logic [CNT_W-1:0] w_rem_m1;
  logic             w_last;
  logic [3:0]       w_next_idx;
  logic             w_final_bit;
  logic             w_do_load;
  logic [7:0]       w_rb_byte;

  assign w_accept    = din_valid & din_ready_q;
  assign w_nb        = (rem_q >= CNT_W'(8)) ? 4'd8 : rem_q[3:0];
  assign w_rem_m1    = rem_q - CNT_W'(1);
  assign w_last      = (idx_q == (nb_q - 4'd1));
  assign w_next_idx  = idx_q + 4'd1;
  // Last bit of the whole load is on prog_out this cycle.
  assign w_final_bit = (state_q == S_SHIFT) && w_last && (rem_q == '0);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    nb_d        = nb_q;
    idx_d       = idx_q;
    prog_out_d  = 1'b0;
    prog_en_d   = 1'b0;
    din_ready_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    rb_sr_d     = rb_sr_q;
    rb_cnt_d    = rb_cnt_q;
    w_do_load   = 1'b0;
    w_rb_byte   = rb_sr_q;

    // Readback: capture the tail for every cycle a bit was shifted.
    if (prog_en_q) begin
      w_rb_byte[rb_cnt_q] = prog_in;
      if ((rb_cnt_q == 3'd7) || w_final_bit) begin
        rb_data_d  = w_rb_byte;
        rb_valid_d = 1'b1;
        rb_sr_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_sr_d  = w_rb_byte;
        rb_cnt_d = rb_cnt_q + 3'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_bits != '0) begin
            rem_d       = num_bits;
            busy_d      = 1'b1;
            din_ready_d = 1'b1;
            state_d     = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_do_load = 1'b1;
        end else begin
          din_ready_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (!w_last) begin
          idx_d      = w_next_idx;
          prog_out_d = shreg_q[w_next_idx[2:0]];
          prog_en_d  = 1'b1;
          rem_d      = w_rem_m1;
          // Open the input for the next byte while its predecessor's last
          // bit is on the wire, so a continuous stream has no gap.
          din_ready_d = (w_next_idx == (nb_q - 4'd1)) && (w_rem_m1 != '0);
        end else if (rem_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else if (w_accept) begin
          w_do_load = 1'b1;
        end else begin
          din_ready_d = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepted byte: its bit 0 goes out in the very next cycle.
    if (w_do_load) begin
      shreg_d    = din;
      nb_d       = w_nb;
      idx_d      = 4'd0;
      prog_out_d = din[0];
      prog_en_d  = 1'b1;
      rem_d      = w_rem_m1;
      // A one-bit byte only occurs as the final bit, so no follow-on byte.
      din_ready_d = 1'b0;
      state_d    = S_SHIFT;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      shreg_q     <= '0;
      nb_q        <= '0;
      idx_q       <= '0;
      prog_out_q  <= 1'b0;
      prog_en_q   <= 1'b0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      rb_sr_q     <= '0;
      rb_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      nb_q        <= nb_d;
      idx_q       <= idx_d;
      prog_out_q  <= prog_out_d;
      prog_en_q   <= prog_en_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      rb_sr_q     <= rb_sr_d;
      rb_cnt_q    <= rb_cnt_d;
    end
  end

  assign din_ready = din_ready_q;
  assign prog_out  = prog_out_q;
  assign prog_en   = prog_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_chain_loader
// Purpose  : Self-checking bench for cfg_chain_loader. Stimulus pushes the
//            expected serial bits and readback bytes into queues; a negedge
//            monitor pops and compares whenever prog_en / rb_valid / done
//            are presented. A behavioural shift-register fabric closes the
//            chain from prog_out back to prog_in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_chain_loader;

  localparam int CNT_W = 24;

  logic             prog_clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_bits;
  logic [7:0]       din;
  logic             din_valid;
  logic             din_ready;
  logic             prog_out;
  logic             prog_en;
  logic             prog_in;
  logic [7:0]       rb_data;
  logic             rb_valid;
  logic             busy;
  logic             done;

  cfg_chain_loader #(.CNT_W(CNT_W)) dut (
    .prog_clk  (prog_clk),
    .rst       (rst),
    .start     (start),
    .num_bits  (num_bits),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .prog_out  (prog_out),
    .prog_en   (prog_en),
    .prog_in   (prog_in),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Fabric model: shift right on prog_en, new bit enters at the top.
  logic [31:0] fab;
  logic [31:0] fab_init = 32'd0;
  int          fab_len  = 16;
  bit          fab_load = 1'b0;
  always @(posedge prog_clk) begin
    if (fab_load)     fab <= fab_init;
    else if (prog_en) fab <= (fab >> 1) | ({31'd0, prog_out} << (fab_len - 1));
  end
  assign prog_in = fab[0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor statistics.
  bit         exp_bits[$];
  logic [7:0] exp_rb[$];
  bit         chk_rb      = 1'b0;
  bit         exp_prev_en = 1'b1;
  bit         prev_en     = 1'b0;
  int         en_seen, gap_seen, rb_seen, ready_seen, done_seen;

  always @(negedge prog_clk) begin
    if (prog_en) begin
      en_seen++;
      if (exp_bits.size() == 0) chk("unexpected_bit", 32'd1, 32'd0);
      else                      chk("prog_out", {31'd0, prog_out}, {31'd0, exp_bits.pop_front()});
    end else if (busy && en_seen > 0) begin
      gap_seen++;
    end
    if (din_ready) ready_seen++;
    if (rb_valid) begin
      rb_seen++;
      if (chk_rb) begin
        if (exp_rb.size() == 0) chk("unexpected_rb", 32'd1, 32'd0);
        else                    chk("rb_data", {24'd0, rb_data}, {24'd0, exp_rb.pop_front()});
      end
    end
    if (done) begin
      done_seen++;
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("done_after_last_bit", {31'd0, prev_en}, {31'd0, exp_prev_en});
    end
    prev_en = prog_en;
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic clear_stats();
    en_seen = 0; gap_seen = 0; rb_seen = 0; ready_seen = 0; done_seen = 0;
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) exp_bits.push_back(b[k]);
  endtask

  task automatic preload_fab(input int len, input logic [31:0] v);
    fab_len  = len;
    fab_init = v;
    fab_load = 1'b1;
    tick();
    fab_load = 1'b0;
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    num_bits = CNT_W'(n);
    tick();
    start    = 1'b0;
    num_bits = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok        = 1'b0;
    din       = b;
    din_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge prog_clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("din_ready_wait", {31'd0, ok}, 32'd1);
    if (ok) tick();
    din_valid = 1'b0;
    din       = 8'h00;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge prog_clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_wait", {31'd0, seen}, 32'd1);
    tick();
  endtask

  task automatic finish_load(input string p, input int n, input int n_rb, input int gaps);
    chk({p, "_en_cycles"}, en_seen, n);
    chk({p, "_gap_cycles"}, gap_seen, gaps);
    chk({p, "_rb_bytes"}, rb_seen, n_rb);
    chk({p, "_bits_left"}, exp_bits.size(), 0);
    chk({p, "_rb_left"}, exp_rb.size(), 0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_prog_out"},  {31'd0, prog_out},  32'd0);
    chk({p, "_prog_en"},   {31'd0, prog_en},   32'd0);
    chk({p, "_din_ready"}, {31'd0, din_ready}, 32'd0);
    chk({p, "_rb_valid"},  {31'd0, rb_valid},  32'd0);
    chk({p, "_rb_data"},   {24'd0, rb_data},   32'd0);
    chk({p, "_busy"},      {31'd0, busy},      32'd0);
    chk({p, "_done"},      {31'd0, done},      32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_bits = '0; din = 8'h00; din_valid = 1'b0;
    fab_load = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    fab_load = 1'b0;
    @(negedge prog_clk);
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Basic 16-bit load, bytes held valid back to back.
    preload_fab(16, 32'd0);
    clear_stats();
    exp_prev_en = 1'b1;
    push_bits(8'hA5, 8);
    push_bits(8'h3C, 8);
    do_start(16);
    send_byte(8'hA5);
    send_byte(8'h3C);
    wait_done(100);
    finish_load("basic", 16, 2, 0);

    // Readback through a 12-bit fabric preloaded with 0x5A3.
    preload_fab(12, 32'h5A3);
    clear_stats();
    chk_rb = 1'b1;
    exp_rb.push_back(8'hA3);
    exp_rb.push_back(8'h05);
    push_bits(8'hFF, 8);
    push_bits(8'h0F, 4);
    do_start(12);
    send_byte(8'hFF);
    send_byte(8'h0F);
    wait_done(100);
    finish_load("readback", 12, 2, 0);
    chk("fabric_after_readback", fab, 32'hFFF);
    chk_rb = 1'b0;

    // 24-bit load with a 3-cycle bubble and a start pulse while busy.
    preload_fab(16, 32'd0);
    clear_stats();
    push_bits(8'h96, 8);
    push_bits(8'h0F, 8);
    push_bits(8'hE1, 8);
    do_start(24);
    send_byte(8'h96);
    repeat (9) tick();
    start = 1'b1; num_bits = CNT_W'(5);
    tick();
    start = 1'b0; num_bits = '0;
    send_byte(8'h0F);
    send_byte(8'hE1);
    wait_done(200);
    finish_load("bubble", 24, 3, 3);

    // Zero-length command.
    clear_stats();
    exp_prev_en = 1'b0;
    do_start(0);
    @(negedge prog_clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    chk("zero_en_cycles", en_seen, 0);
    chk("zero_ready_cycles", ready_seen, 0);
    chk("zero_rb_bytes", rb_seen, 0);
    chk("zero_done_count", done_seen, 1);

    // Abort after 5 bits of a 16-bit load.
    clear_stats();
    exp_prev_en = 1'b1;
    push_bits(8'hA5, 8);
    do_start(16);
    send_byte(8'hA5);
    repeat (4) tick();
    rst = 1'b1;
    @(posedge prog_clk);
    @(negedge prog_clk);
    chk_zero("abort");
    tick();
    rst = 1'b0;
    exp_bits.delete();
    repeat (3) tick();
    chk("abort_en_cycles", en_seen, 5);
    chk("abort_no_done", done_seen, 0);

    // Restart with an 8-bit load after the abort.
    preload_fab(8, 32'h3C);
    clear_stats();
    chk_rb = 1'b1;
    exp_rb.push_back(8'h3C);
    push_bits(8'h81, 8);
    do_start(8);
    send_byte(8'h81);
    wait_done(100);
    finish_load("restart", 8, 1, 0);
    chk("fabric_after_restart", fab, 32'h81);
    chk_rb = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
